// File: rtl/sram_dp_arbiter_if.sv
// Requester-side bus of sram_dp_arbiter: four packed request channels plus read responses.
// The arbiter takes the slave modport; requesters (or a testbench) drive the master side.
interface sram_dp_arbiter_if #(
  parameter int BITS       = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [3:0]              req_valid;
  logic [3:0]              req_ready;
  logic [3:0]              req_we;
  logic [4*ADDR_WIDTH-1:0] req_addr;
  logic [4*BITS-1:0]       req_wdata;
  logic [3:0]              rsp_valid;
  logic [4*BITS-1:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_dp_arbiter.sv
// Four-requester round-robin arbiter onto a dual-port SRAM (ports A and B).
// Optional macro SRAM_DP_ARBITER_PERF_EN adds saturating grant/conflict counters.
module sram_dp_arbiter #(
  parameter int BITS       = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  sram_dp_arbiter_if.slave      bus,
  output logic                  CENA,
  output logic                  CENB,
  output logic                  WENA,
  output logic                  WENB,
  output logic [ADDR_WIDTH-1:0] AA,
  output logic [ADDR_WIDTH-1:0] AB,
  output logic [BITS-1:0]       DA,
  output logic [BITS-1:0]       DB,
  input  logic [BITS-1:0]       QA,
  input  logic [BITS-1:0]       QB
`ifdef SRAM_DP_ARBITER_PERF_EN
  ,
  output logic [15:0]           grant_cnt,
  output logic [15:0]           conflict_cnt
`endif
);

  logic [1:0]              ptr;
  logic                    a_found, b_found, conflict;
  logic [1:0]              a_idx, b_idx, cand;
  logic                    grant_a, grant_b, blocked;
  logic [ADDR_WIDTH-1:0]   addr_a, addr_b;
  logic [BITS-1:0]         wdata_a, wdata_b;
  logic                    we_a, we_b;
  logic                    pend_a, pend_b;
  logic [1:0]              pend_a_idx, pend_b_idx;
  logic [4*BITS-1:0]       rdata_q, rdata_c;
  logic [3:0]              rsp_valid_c;

  // Scan from ptr; the first valid requester takes port A, the next one is the port-B candidate.
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = 2'd0;
    b_idx   = 2'd0;
    cand    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (bus.req_valid[cand]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = cand;
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = cand;
        end
      end
    end
    addr_a   = bus.req_addr[a_idx*ADDR_WIDTH +: ADDR_WIDTH];
    addr_b   = bus.req_addr[b_idx*ADDR_WIDTH +: ADDR_WIDTH];
    wdata_a  = bus.req_wdata[a_idx*BITS +: BITS];
    wdata_b  = bus.req_wdata[b_idx*BITS +: BITS];
    we_a     = bus.req_we[a_idx];
    we_b     = bus.req_we[b_idx];
    conflict = b_found && (addr_a == addr_b) && (we_a || we_b);
    grant_a  = RST_N && a_found;
    grant_b  = RST_N && b_found && !conflict;
    blocked  = RST_N && b_found && conflict;
  end

  always_comb begin
    bus.req_ready = 4'b0000;
    if (grant_a) bus.req_ready[a_idx] = 1'b1;
    if (grant_b) bus.req_ready[b_idx] = 1'b1;
    CENA = ~grant_a;
    WENA = grant_a ? ~we_a : 1'b1;
    AA   = grant_a ? addr_a : '0;
    DA   = grant_a ? wdata_a : '0;
    CENB = ~grant_b;
    WENB = grant_b ? ~we_b : 1'b1;
    AB   = grant_b ? addr_b : '0;
    DB   = grant_b ? wdata_b : '0;
  end

  // Reads remember which port served them so the next-cycle Q can be steered to the requester.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr        <= 2'd0;
      pend_a     <= 1'b0;
      pend_b     <= 1'b0;
      pend_a_idx <= 2'd0;
      pend_b_idx <= 2'd0;
      rdata_q    <= '0;
    end else begin
      if (grant_b)      ptr <= b_idx + 2'd1;
      else if (grant_a) ptr <= a_idx + 2'd1;
      pend_a     <= grant_a && !we_a;
      pend_b     <= grant_b && !we_b;
      pend_a_idx <= a_idx;
      pend_b_idx <= b_idx;
      rdata_q    <= rdata_c;
    end
  end

  always_comb begin
    rsp_valid_c = 4'b0000;
    rdata_c     = rdata_q;
    if (pend_a) begin
      rsp_valid_c[pend_a_idx]            = 1'b1;
      rdata_c[pend_a_idx*BITS +: BITS]   = QA;
    end
    if (pend_b) begin
      rsp_valid_c[pend_b_idx]            = 1'b1;
      rdata_c[pend_b_idx*BITS +: BITS]   = QB;
    end
  end

  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_rdata = rdata_c;

`ifdef SRAM_DP_ARBITER_PERF_EN
  logic [15:0] n_grants;
  assign n_grants = {15'd0, grant_a} + {15'd0, grant_b};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      grant_cnt    <= 16'd0;
      conflict_cnt <= 16'd0;
    end else begin
      grant_cnt <= (grant_cnt > 16'hFFFF - n_grants) ? 16'hFFFF : grant_cnt + n_grants;
      if (blocked && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_dp_arbiter.sv
// Randomized self-checking bench for sram_dp_arbiter with a behavioural SRAM and reference model.
// Define SRAM_DP_ARBITER_PERF_EN to also check the performance counters.
module tb_sram_dp_arbiter;
  localparam int BITS = 32;
  localparam int AW   = 10;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  sram_dp_arbiter_if #(.BITS(BITS), .ADDR_WIDTH(AW)) bus ();

  logic          CENA, CENB, WENA, WENB;
  logic [AW-1:0] AA, AB;
  logic [BITS-1:0] DA, DB, QA, QB;
`ifdef SRAM_DP_ARBITER_PERF_EN
  logic [15:0] grant_cnt, conflict_cnt;
`endif

  sram_dp_arbiter #(.BITS(BITS), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus),
    .CENA(CENA), .CENB(CENB), .WENA(WENA), .WENB(WENB),
    .AA(AA), .AB(AB), .DA(DA), .DB(DB), .QA(QA), .QB(QB)
`ifdef SRAM_DP_ARBITER_PERF_EN
    , .grant_cnt(grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  // Behavioural dual-port SRAM: read data appears the cycle after the access.
  logic [BITS-1:0] sram [1024] = '{default: '0};
  always @(posedge CLK) begin
    if (!CENA) begin
      if (WENA) QA <= sram[AA];
      else      sram[AA] <= DA;
    end
    if (!CENB) begin
      if (WENB) QB <= sram[AB];
      else      sram[AB] <= DB;
    end
  end

  int checks = 0;
  int errors = 0;

  int              m_ptr;
  logic [BITS-1:0] m_mem [1024];
  bit              m_pend [4];
  logic [BITS-1:0] m_pend_data [4];
  logic [BITS-1:0] m_hold [4];
  int              m_gcnt, m_ccnt;

  logic [3:0]      s_valid, s_we;
  logic [AW-1:0]   s_addr [4];
  logic [BITS-1:0] s_wdata [4];
  logic [3:0]      granted;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    bus.req_valid = s_valid;
    bus.req_we    = s_we;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*AW +: AW]      = s_addr[i];
      bus.req_wdata[i*BITS +: BITS] = s_wdata[i];
    end
  endtask

  task automatic setReq(input int i, input bit v, input bit we, input logic [AW-1:0] addr,
                        input logic [BITS-1:0] data);
    s_valid[i] = v;
    s_we[i]    = we;
    s_addr[i]  = addr;
    s_wdata[i] = data;
  endtask

  // One clock cycle: check responses, drive requests, check grants/ports, advance the model.
  task automatic runCycle(input bit rst, input bit late_rst, output logic [3:0] gnt);
    logic [3:0]        exp_v;
    logic [4*BITS-1:0] exp_d;
    logic [3:0]        exp_ready;
    logic [AW+BITS+1:0] exp_pa, exp_pb;
    int  order[$];
    int  a, b;
    bit  ga, gb, blk;

    for (int i = 0; i < 4; i++) begin
      exp_v[i] = m_pend[i];
      exp_d[i*BITS +: BITS] = m_pend[i] ? m_pend_data[i] : m_hold[i];
      m_hold[i] = exp_d[i*BITS +: BITS];
    end
    checkOutput("rsp_valid", 128'(bus.rsp_valid), 128'(exp_v));
    checkOutput("rsp_rdata", 128'(bus.rsp_rdata), 128'(exp_d));

    RST_N = !rst;
    applyStimulus();
    #1;

    for (int k = 0; k < 4; k++)
      if (s_valid[(m_ptr + k) % 4]) order.push_back((m_ptr + k) % 4);
    a   = (order.size() >= 1) ? order[0] : 0;
    b   = (order.size() >= 2) ? order[1] : 0;
    ga  = !rst && order.size() >= 1;
    blk = !rst && order.size() >= 2 && s_addr[a] == s_addr[b] && (s_we[a] || s_we[b]);
    gb  = !rst && order.size() >= 2 && !blk;

    exp_ready = 4'b0000;
    if (ga) exp_ready[a] = 1'b1;
    if (gb) exp_ready[b] = 1'b1;
    exp_pa = ga ? {1'b0, !s_we[a], s_addr[a], s_wdata[a]} : {2'b11, AW'(0), BITS'(0)};
    exp_pb = gb ? {1'b0, !s_we[b], s_addr[b], s_wdata[b]} : {2'b11, AW'(0), BITS'(0)};
    checkOutput("req_ready", 128'(bus.req_ready), 128'(exp_ready));
    checkOutput("port_a", 128'({CENA, WENA, AA, DA}), 128'(exp_pa));
    checkOutput("port_b", 128'({CENB, WENB, AB, DB}), 128'(exp_pb));
`ifdef SRAM_DP_ARBITER_PERF_EN
    checkOutput("grant_cnt", 128'(grant_cnt), 128'(m_gcnt));
    checkOutput("conflict_cnt", 128'(conflict_cnt), 128'(m_ccnt));
`endif
    gnt = exp_ready;

    if (late_rst) begin
      @(negedge CLK);
      RST_N = 1'b0;
    end

    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    if (rst || late_rst) begin
      m_ptr  = 0;
      m_gcnt = 0;
      m_ccnt = 0;
      for (int i = 0; i < 4; i++) m_hold[i] = '0;
    end else begin
      if (ga && !s_we[a]) begin m_pend[a] = 1'b1; m_pend_data[a] = m_mem[s_addr[a]]; end
      if (gb && !s_we[b]) begin m_pend[b] = 1'b1; m_pend_data[b] = m_mem[s_addr[b]]; end
      if (ga && s_we[a]) m_mem[s_addr[a]] = s_wdata[a];
      if (gb && s_we[b]) m_mem[s_addr[b]] = s_wdata[b];
      if (gb)      m_ptr = (b + 1) % 4;
      else if (ga) m_ptr = (a + 1) % 4;
      m_gcnt = (m_gcnt + int'(ga) + int'(gb) > 65535) ? 65535 : m_gcnt + int'(ga) + int'(gb);
      if (blk && m_ccnt < 65535) m_ccnt++;
    end

    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 4'b0000;
    for (int c = 0; c < n; c++) runCycle(1'b0, 1'b0, granted);
  endtask

  task automatic doReset();
    s_valid = 4'b0000;
    runCycle(1'b1, 1'b0, granted);
  endtask

  initial begin
    m_ptr = 0;
    m_gcnt = 0;
    m_ccnt = 0;
    for (int i = 0; i < 1024; i++) m_mem[i] = '0;
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 1'b0;
      m_pend_data[i] = '0;
      m_hold[i] = '0;
      setReq(i, 1'b0, 1'b0, '0, '0);
    end
    applyStimulus();
    @(posedge CLK);
    #1;
    doReset();
    doReset();

    $display("[TB] write then read back");
    setReq(0, 1'b1, 1'b1, 10'h005, 32'hDEAD_BEEF);
    runCycle(1'b0, 1'b0, granted);
    s_valid = 4'b0000;
    setReq(2, 1'b1, 1'b0, 10'h005, 32'h0);
    runCycle(1'b0, 1'b0, granted);
    idle(2);

    $display("[TB] four readers rotate");
    doReset();
    for (int i = 0; i < 4; i++) setReq(i, 1'b1, 1'b0, AW'(i + 32), 32'h0);
    for (int c = 0; c < 3; c++) runCycle(1'b0, 1'b0, granted);
    idle(1);

    $display("[TB] write/read address clash");
    doReset();
    setReq(1, 1'b1, 1'b1, 10'h010, 32'hCAFE_F00D);
    setReq(3, 1'b1, 1'b0, 10'h010, 32'h0);
    runCycle(1'b0, 1'b0, granted);
    s_valid[1] = 1'b0;
    runCycle(1'b0, 1'b0, granted);
    idle(2);

    $display("[TB] shared read address");
    doReset();
    setReq(0, 1'b1, 1'b0, 10'h3FF, 32'h0);
    setReq(2, 1'b1, 1'b0, 10'h3FF, 32'h0);
    runCycle(1'b0, 1'b0, granted);
    idle(2);

    $display("[TB] reset cancels pending read");
    setReq(0, 1'b1, 1'b0, 10'h005, 32'h0);
    runCycle(1'b0, 1'b1, granted);
    for (int i = 0; i < 4; i++) setReq(i, 1'b1, 1'b0, AW'(i + 64), 32'h0);
    runCycle(1'b0, 1'b0, granted);
    idle(2);

    $display("[TB] randomized traffic");
    granted = 4'b0000;
    s_valid = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      bit rst, late;
      for (int i = 0; i < 4; i++)
        if (!s_valid[i] || granted[i])
          setReq(i, $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                 AW'($urandom_range(0, 7)), BITS'($urandom));
      rst  = ($urandom_range(0, 99) == 0);
      late = !rst && ($urandom_range(0, 99) == 0);
      runCycle(rst, late, granted);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
